ldpc_decoder: RTL and testbench

LDPC_DECODER -- requirements
Module: ldpc_decoder

---
 rtl/ldpc_decoder.sv | 199 +++++++++++++++++++
 tb/tb_ldpc_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_decoder.sv
// rtl/ldpc_decoder.sv - single-error-correcting decoder for a 12-bit (4-bit message) code
//
// Purpose:
//   Accepts a 12-bit hard-decision codeword. It computes the 8-bit syndrome and,
//   when the syndrome is non-zero, searches the bit positions one per cycle for a
//   matching single-bit-error syndrome. The decoder returns the corrected word, or
//   the raw word flagged uncorrectable. It also keeps saturating counts of the
//   corrected and uncorrectable results that were delivered.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid_i    code_in_i holds a codeword
//   in_ready_o    decoder idle, can accept a codeword
//   code_in_i     received 12-bit codeword
//   out_valid_o   result registers hold a valid result
//   out_ready_i   downstream accepts the result
//   msg_out_o     decoded message {w[4],w[2],w[1],w[0]}
//   code_out_o    codeword after correction (raw word when uncorrectable)
//   status_o      00 clean, 01 corrected, 10 uncorrectable
//   err_pos_o     corrected bit index, 0 unless status_o is 01
//   cnt_clr_i     synchronous clear of both counters
//   corr_cnt_o    delivered results with status 01, saturating
//   uncorr_cnt_o  delivered results with status 10, saturating

module ldpc_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [11:0]      code_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       msg_out_o,
  output logic [11:0]      code_out_o,
  output logic [1:0]       status_o,
  output logic [3:0]       err_pos_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] uncorr_cnt_o
);

  typedef enum logic [1:0] {IDLE, SYND, SEARCH, DONE} state_e;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  state_e           state_q;
  logic [11:0]      w_q;
  logic [7:0]       syn_q;
  logic [3:0]       idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [3:0]       msg_q;
  logic [11:0]      code_q;
  logic [1:0]       status_q;
  logic [3:0]       err_pos_q;
  logic [CNT_W-1:0] corr_q;
  logic [CNT_W-1:0] uncorr_q;

  logic [7:0]       syn_d;
  logic [7:0]       col_d;
  logic [11:0]      fixed_d;
  logic             out_hs;

  function automatic logic [3:0] msg_of(input logic [11:0] c);
    return {c[4], c[2], c[1], c[0]};
  endfunction

  always_comb begin
    syn_d[7] = w_q[11] ^ w_q[4] ^ w_q[2] ^ w_q[1];
    syn_d[6] = w_q[10] ^ w_q[2] ^ w_q[0];
    syn_d[5] = w_q[9]  ^ w_q[0];
    syn_d[4] = w_q[8]  ^ w_q[4] ^ w_q[2] ^ w_q[1];
    syn_d[3] = w_q[7]  ^ w_q[4] ^ w_q[2] ^ w_q[1];
    syn_d[2] = w_q[6]  ^ w_q[2];
    syn_d[1] = w_q[5]  ^ w_q[2] ^ w_q[1] ^ w_q[0];
    syn_d[0] = w_q[3]  ^ w_q[2] ^ w_q[1] ^ w_q[0];
  end

  // Syndrome produced by a single error at the candidate index.
  always_comb begin
    col_d = 8'h00;
    case (idx_q)
      4'd0:    col_d = 8'h63;
      4'd1:    col_d = 8'h9B;
      4'd2:    col_d = 8'hDF;
      4'd3:    col_d = 8'h01;
      4'd4:    col_d = 8'h98;
      4'd5:    col_d = 8'h02;
      4'd6:    col_d = 8'h04;
      4'd7:    col_d = 8'h08;
      4'd8:    col_d = 8'h10;
      4'd9:    col_d = 8'h20;
      4'd10:   col_d = 8'h40;
      4'd11:   col_d = 8'h80;
      default: col_d = 8'h00;
    endcase
  end

  assign fixed_d = w_q ^ (12'd1 << idx_q);
  assign out_hs  = out_valid_q & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      syn_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      msg_q       <= '0;
      code_q      <= '0;
      status_q    <= ST_CLEAN;
      err_pos_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            w_q        <= code_in_i;
            in_ready_q <= 1'b0;
            state_q    <= SYND;
          end
        end
        SYND: begin
          syn_q <= syn_d;
          idx_q <= '0;
          if (syn_d == 8'h00) begin
            code_q      <= w_q;
            msg_q       <= msg_of(w_q);
            status_q    <= ST_CLEAN;
            err_pos_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (syn_q == col_d) begin
            code_q      <= fixed_d;
            msg_q       <= msg_of(fixed_d);
            status_q    <= ST_CORR;
            err_pos_q   <= idx_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (idx_q == 4'd11) begin
            // No single-bit explanation: hand back the word as received.
            code_q      <= w_q;
            msg_q       <= msg_of(w_q);
            status_q    <= ST_UNCORR;
            err_pos_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counters: clear has priority over a coincident increment; both saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (cnt_clr_i) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (out_hs) begin
      if (status_q == ST_CORR && corr_q != '1)
        corr_q <= corr_q + CNT_W'(1);
      if (status_q == ST_UNCORR && uncorr_q != '1)
        uncorr_q <= uncorr_q + CNT_W'(1);
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign msg_out_o    = msg_q;
  assign code_out_o   = code_q;
  assign status_o     = status_q;
  assign err_pos_o    = err_pos_q;
  assign corr_cnt_o   = corr_q;
  assign uncorr_cnt_o = uncorr_q;

endmodule

// File: tb/tb_ldpc_decoder.sv
// tb/tb_ldpc_decoder.sv - self-checking bench for ldpc_decoder

module tb_ldpc_decoder;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      code_in;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       msg_out;
  logic [11:0]      code_out;
  logic [1:0]       status;
  logic [3:0]       err_pos;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  always #5 clk = ~clk;

  ldpc_decoder #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .code_in_i    (code_in),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .msg_out_o    (msg_out),
    .code_out_o   (code_out),
    .status_o     (status),
    .err_pos_o    (err_pos),
    .cnt_clr_i    (cnt_clr),
    .corr_cnt_o   (corr_cnt),
    .uncorr_cnt_o (uncorr_cnt)
  );

  int checks = 0;
  int errors = 0;
  int corr_m = 0;
  int uncorr_m = 0;

  logic [7:0] col_tab [12];

  typedef struct {
    logic [11:0] code;
    logic [11:0] ecode;
    logic [3:0]  emsg;
    logic [1:0]  est;
    logic [3:0]  eerr;
    int          elat;
    int          hold;
  } vec_t;

  vec_t tab [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Syndrome as the XOR of the single-error columns of the set bits.
  function automatic logic [7:0] ref_syn(input logic [11:0] c);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 12; i++)
      if (c[i]) s ^= col_tab[i];
    return s;
  endfunction

  task automatic ref_decode(input logic [11:0] c, output logic [11:0] ec, output logic [1:0] est,
                            output logic [3:0] eerr, output int elat);
    logic [7:0] s;
    s = ref_syn(c);
    ec = c; est = 2'd0; eerr = 4'd0; elat = 2;
    if (s != 8'h00) begin
      est = 2'd2; elat = 14;
      for (int j = 0; j < 12; j++)
        if (col_tab[j] == s) begin
          est = 2'd1; eerr = j[3:0]; ec = c ^ (12'd1 << j); elat = 3 + j;
        end
    end
  endtask

  task automatic count_model(input logic [1:0] est, input bit clr);
    if (clr) begin
      corr_m = 0; uncorr_m = 0;
    end else if (est == 2'd1) begin
      if (corr_m < int'(CNT_MAX)) corr_m++;
    end else if (est == 2'd2) begin
      if (uncorr_m < int'(CNT_MAX)) uncorr_m++;
    end
  endtask

  // Called at a negedge with the decoder idle; returns at a negedge after the output handshake.
  task automatic run(input logic [11:0] c, input logic [11:0] ec, input logic [3:0] emsg,
                     input logic [1:0] est, input logic [3:0] eerr, input int elat,
                     input int hold, input bit clr);
    int lat;
    bit seen;
    in_valid = 1'b1; code_in = c; out_ready = 1'b0;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    lat = 0; seen = 0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      if (hold == 0) in_valid = 1'b0;
      if (out_valid) seen = 1;
      else if (lat == 1) chk("in_ready_busy", in_ready, 0);
    end
    chk("latency", lat, elat);
    chk("msg_out", msg_out, emsg);
    chk("code_out", code_out, ec);
    chk("status", status, est);
    chk("err_pos", err_pos, eerr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_msg", msg_out, emsg);
      chk("hold_code", code_out, ec);
      chk("hold_status", status, est);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = clr;
    @(negedge clk);
    out_ready = 1'b0; cnt_clr = 1'b0;
    count_model(est, clr);
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("corr_cnt", corr_cnt, corr_m);
    chk("uncorr_cnt", uncorr_cnt, uncorr_m);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_msg", msg_out, 0);
    chk("rst_code", code_out, 0);
    chk("rst_status", status, 0);
    chk("rst_err_pos", err_pos, 0);
    chk("rst_corr", corr_cnt, 0);
    chk("rst_uncorr", uncorr_cnt, 0);
  endtask

  task automatic run_model(input logic [11:0] c, input int hold, input bit clr);
    logic [11:0] ec;
    logic [1:0]  est;
    logic [3:0]  eerr;
    int          elat;
    ref_decode(c, ec, est, eerr, elat);
    run(c, ec, {ec[4], ec[2], ec[1], ec[0]}, est, eerr, elat, hold, clr);
  endtask

  initial begin
    col_tab = '{8'h63, 8'h9B, 8'hDF, 8'h01, 8'h98, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    tab[0] = '{12'h613, 12'h613, 4'hB, 2'd0, 4'd0,  2, 0};
    tab[1] = '{12'h611, 12'h613, 4'hB, 2'd1, 4'd1,  4, 0};
    tab[2] = '{12'hE13, 12'h613, 4'hB, 2'd1, 4'd11, 14, 0};
    tab[3] = '{12'h003, 12'h003, 4'h3, 2'd2, 4'd0,  14, 0};
    tab[4] = '{12'hDEC, 12'hDEC, 4'h4, 2'd0, 4'd0,  2, 5};
    tab[5] = '{12'h612, 12'h613, 4'hB, 2'd1, 4'd0,  3, 0};
    tab[6] = '{12'h617, 12'h613, 4'hB, 2'd1, 4'd2,  5, 0};
    tab[7] = '{12'h61B, 12'h613, 4'hB, 2'd1, 4'd3,  6, 0};
    tab[8] = '{12'h000, 12'h000, 4'h0, 2'd0, 4'd0,  2, 2};

    rst_n = 1'b0; in_valid = 1'b0; code_in = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    foreach (tab[i])
      run(tab[i].code, tab[i].ecode, tab[i].emsg, tab[i].est, tab[i].eerr, tab[i].elat, tab[i].hold, 1'b0);

    // Random codewords with 0, 1 or 2 bit errors.
    for (int n = 0; n < 60; n++) begin
      logic [11:0] w;
      logic [7:0]  s;
      int          nerr;
      int          b0, b1;
      w = 12'($urandom);
      s = ref_syn(w);
      w[3] ^= s[0]; w[5] ^= s[1]; w[6] ^= s[2]; w[7] ^= s[3];
      w[8] ^= s[4]; w[9] ^= s[5]; w[10] ^= s[6]; w[11] ^= s[7];
      nerr = $urandom_range(0, 2);
      b0 = $urandom_range(0, 11);
      b1 = (b0 + $urandom_range(1, 11)) % 12;
      if (nerr >= 1) w[b0] = ~w[b0];
      if (nerr == 2) w[b1] = ~w[b1];
      run_model(w, $urandom_range(0, 2), 1'b0);
    end

    // Drive the uncorrectable counter into saturation.
    for (int n = 0; n < 16; n++)
      run(12'h003, 12'h003, 4'h3, 2'd2, 4'd0, 14, 0, 1'b0);
    chk("uncorr_saturated", uncorr_cnt, 15);

    // Clear coinciding with an increment: clear wins.
    run(12'h003, 12'h003, 4'h3, 2'd2, 4'd0, 14, 0, 1'b1);
    run(12'h611, 12'h613, 4'hB, 2'd1, 4'd1, 4, 0, 1'b0);

    // Reset in the middle of the search for 0x611.
    in_valid = 1'b1; code_in = 12'h611;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    corr_m = 0; uncorr_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(12'h613, 12'h613, 4'hB, 2'd0, 4'd0, 2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
